// File: rtl/koder_ulazni_sklop_if.sv
// -----------------------------------------------------------------------------
// koder_ulazni_sklop_if
//
// Purpose:
//   Groups the byte-stream input and the parallel frame output of the koder
//   front end (koder_ulazni_sklop) into one bundle.
//
// Signals:
//   ulaz_bajt    [7:0]               incoming byte
//   ulaz_valid                       ulaz_bajt is valid
//   ulaz_ready                       front end accepts a byte this cycle
//   ponisti                          synchronous frame abort
//   ime          [8*IME_BAJTOVA-1:0] assembled name, first byte in MSBs
//   indeks       [4*INDEKS_CIFARA-1:0] assembled BCD index, first digit in MSBs
//   izlaz_valid                      ime/indeks hold a complete frame
//   izlaz_ready                      downstream koder accepts the frame
//   greska                           one-cycle pulse when a frame is rejected
//
// Modports:
//   master - the side that feeds bytes and consumes frames (source/koder)
//   slave  - the front end itself
// -----------------------------------------------------------------------------
interface koder_ulazni_sklop_if #(
    parameter int IME_BAJTOVA   = 5,
    parameter int INDEKS_CIFARA = 3
);
    logic [7:0]                   ulaz_bajt;
    logic                         ulaz_valid;
    logic                         ulaz_ready;
    logic                         ponisti;
    logic [8*IME_BAJTOVA-1:0]     ime;
    logic [4*INDEKS_CIFARA-1:0]   indeks;
    logic                         izlaz_valid;
    logic                         izlaz_ready;
    logic                         greska;

    modport master (
        output ulaz_bajt,
        output ulaz_valid,
        input  ulaz_ready,
        output ponisti,
        input  ime,
        input  indeks,
        input  izlaz_valid,
        output izlaz_ready,
        input  greska
    );

    modport slave (
        input  ulaz_bajt,
        input  ulaz_valid,
        output ulaz_ready,
        input  ponisti,
        output ime,
        output indeks,
        output izlaz_valid,
        input  izlaz_ready,
        output greska
    );
endinterface

// File: rtl/koder_ulazni_sklop.sv
// -----------------------------------------------------------------------------
// koder_ulazni_sklop
//
// Purpose:
//   Byte-serial front end of the koder stage. A frame is IME_BAJTOVA ASCII
//   name characters followed by INDEKS_CIFARA ASCII index digits. The name is
//   assembled into a parallel word (first byte in the MSBs), the digits into a
//   BCD word (first digit in the MSBs). The finished frame is held stable with
//   izlaz_valid until the koder side accepts it with izlaz_ready.
//   A non-digit byte in the index part rejects the frame (greska pulse);
//   ponisti aborts the current frame without a greska pulse.
//
// Ports:
//   clk   - single clock, rising edge
//   rst   - asynchronous, active-high reset
//   bus   - koder_ulazni_sklop_if.slave (byte stream in, frame out, abort,
//           error pulse)
//
// Optional build macro:
//   KODER_CHECKSUM_EN - each frame carries one extra trailing byte equal to
//   the XOR of all preceding frame bytes; a mismatch rejects the frame.
//   Without the macro the frame ends at the last index digit.
// -----------------------------------------------------------------------------
module koder_ulazni_sklop #(
    parameter int IME_BAJTOVA   = 5,
    parameter int INDEKS_CIFARA = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    koder_ulazni_sklop_if.slave   bus
);

    localparam int IME_W    = 8 * IME_BAJTOVA;
    localparam int INDEKS_W = 4 * INDEKS_CIFARA;
    localparam int MAX_CNT  = (IME_BAJTOVA > INDEKS_CIFARA) ? IME_BAJTOVA : INDEKS_CIFARA;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] ZADNJI_IME    = CNT_W'(IME_BAJTOVA - 1);
    localparam logic [CNT_W-1:0] ZADNJI_INDEKS = CNT_W'(INDEKS_CIFARA - 1);

    localparam logic [1:0] PRIJEM_IME    = 2'd0;
    localparam logic [1:0] PRIJEM_INDEKS = 2'd1;
    localparam logic [1:0] IZLAZ         = 2'd2;
`ifdef KODER_CHECKSUM_EN
    localparam logic [1:0] PRIJEM_SUMA   = 2'd3;
`endif

    logic [1:0]          stanje;
    logic [CNT_W-1:0]    cnt;
    logic [IME_W-1:0]    ime_r;
    logic [INDEKS_W-1:0] indeks_r;
    logic                izlaz_valid_r;
    logic                greska_r;
    logic                ulaz_ready_c;
    logic                prihvat;
`ifdef KODER_CHECKSUM_EN
    logic [7:0]          suma;
`endif

    // ASCII '0'..'9'
    function automatic logic je_cifra(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Ready is a pure decode of the state: no bytes are taken while a frame
    // is waiting for the koder, and there is no bypass on the transfer cycle.
    assign ulaz_ready_c = (stanje != IZLAZ);
    assign prihvat      = bus.ulaz_valid && ulaz_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stanje        <= PRIJEM_IME;
            cnt           <= '0;
            ime_r         <= '0;
            indeks_r      <= '0;
            izlaz_valid_r <= 1'b0;
            greska_r      <= 1'b0;
`ifdef KODER_CHECKSUM_EN
            suma          <= '0;
`endif
        end else begin
            greska_r <= 1'b0;
            if (bus.ponisti) begin
                // Abort wins over any byte or transfer in the same cycle.
                stanje        <= PRIJEM_IME;
                cnt           <= '0;
                izlaz_valid_r <= 1'b0;
`ifdef KODER_CHECKSUM_EN
                suma          <= '0;
`endif
            end else begin
                case (stanje)
                    PRIJEM_IME: begin
                        if (prihvat) begin
                            // Cast keeps the low IME_W bits, i.e. shift in at the LSB end.
                            ime_r <= IME_W'({ime_r, bus.ulaz_bajt});
`ifdef KODER_CHECKSUM_EN
                            suma  <= suma ^ bus.ulaz_bajt;
`endif
                            if (cnt == ZADNJI_IME) begin
                                cnt    <= '0;
                                stanje <= PRIJEM_INDEKS;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end

                    PRIJEM_INDEKS: begin
                        if (prihvat) begin
                            if (je_cifra(bus.ulaz_bajt)) begin
                                indeks_r <= INDEKS_W'({indeks_r, bus.ulaz_bajt[3:0]});
`ifdef KODER_CHECKSUM_EN
                                suma     <= suma ^ bus.ulaz_bajt;
`endif
                                if (cnt == ZADNJI_INDEKS) begin
                                    cnt <= '0;
`ifdef KODER_CHECKSUM_EN
                                    stanje <= PRIJEM_SUMA;
`else
                                    stanje        <= IZLAZ;
                                    izlaz_valid_r <= 1'b1;
`endif
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end else begin
                                // Bad digit: byte is consumed, frame restarts.
                                greska_r <= 1'b1;
                                cnt      <= '0;
                                stanje   <= PRIJEM_IME;
`ifdef KODER_CHECKSUM_EN
                                suma     <= '0;
`endif
                            end
                        end
                    end

`ifdef KODER_CHECKSUM_EN
                    PRIJEM_SUMA: begin
                        if (prihvat) begin
                            if (bus.ulaz_bajt == suma) begin
                                stanje        <= IZLAZ;
                                izlaz_valid_r <= 1'b1;
                            end else begin
                                greska_r <= 1'b1;
                                stanje   <= PRIJEM_IME;
                            end
                            cnt  <= '0;
                            suma <= '0;
                        end
                    end
`endif

                    IZLAZ: begin
                        if (izlaz_valid_r && bus.izlaz_ready) begin
                            izlaz_valid_r <= 1'b0;
                            stanje        <= PRIJEM_IME;
                        end
                    end

                    default: begin
                        stanje        <= PRIJEM_IME;
                        cnt           <= '0;
                        izlaz_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ulaz_ready  = ulaz_ready_c;
    assign bus.ime         = ime_r;
    assign bus.indeks      = indeks_r;
    assign bus.izlaz_valid = izlaz_valid_r;
    assign bus.greska      = greska_r;

endmodule

// File: tb/tb_koder_ulazni_sklop.sv
// -----------------------------------------------------------------------------
// tb_koder_ulazni_sklop
//
// Directed bench for koder_ulazni_sklop at default parameters. Expected frame
// words are hand-computed from the ASCII of the stimulus strings. With
// KODER_CHECKSUM_EN defined every complete frame is followed by its XOR byte
// and the checksum cases are exercised as well.
// -----------------------------------------------------------------------------
module tb_koder_ulazni_sklop;

    localparam int IME_BAJTOVA   = 5;
    localparam int INDEKS_CIFARA = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    koder_ulazni_sklop_if #(
        .IME_BAJTOVA   (IME_BAJTOVA),
        .INDEKS_CIFARA (INDEKS_CIFARA)
    ) bus_if ();

    koder_ulazni_sklop #(
        .IME_BAJTOVA   (IME_BAJTOVA),
        .INDEKS_CIFARA (INDEKS_CIFARA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus_if.ulaz_bajt  = b;
        bus_if.ulaz_valid = 1'b1;
        tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle();
        bus_if.ulaz_valid = 1'b0;
        tick();
    endtask

`ifdef KODER_CHECKSUM_EN
    function automatic logic [7:0] xor_str(input string s);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < s.len(); i++) x = x ^ s[i];
        return x;
    endfunction
`endif

    task automatic check_frame(input string tag, input logic [39:0] e_ime, input logic [11:0] e_indeks);
        check({tag, "_valid"},  {63'd0, bus_if.izlaz_valid}, 64'd1);
        check({tag, "_ime"},    {24'd0, bus_if.ime},         {24'd0, e_ime});
        check({tag, "_indeks"}, {52'd0, bus_if.indeks},      {52'd0, e_indeks});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ime"},    {24'd0, bus_if.ime},          64'd0);
        check({tag, "_indeks"}, {52'd0, bus_if.indeks},       64'd0);
        check({tag, "_valid"},  {63'd0, bus_if.izlaz_valid},  64'd0);
        check({tag, "_greska"}, {63'd0, bus_if.greska},       64'd0);
        check({tag, "_ready"},  {63'd0, bus_if.ulaz_ready},   64'd1);
    endtask

    initial begin
        bus_if.ulaz_bajt   = 8'h00;
        bus_if.ulaz_valid  = 1'b0;
        bus_if.ponisti     = 1'b0;
        bus_if.izlaz_ready = 1'b0;

        // Reset
        #2 rst = 1'b1;
        #1;
        check_reset_state("reset");
        tick();
        rst = 1'b0;
        tick();

        // Marko/123, koder always ready
        bus_if.izlaz_ready = 1'b1;
        send_str("Marko12");
        check("t1_pre_valid", {63'd0, bus_if.izlaz_valid}, 64'd0);
        send("3");
`ifdef KODER_CHECKSUM_EN
        check("t1_pre_sum_valid", {63'd0, bus_if.izlaz_valid}, 64'd0);
        send(xor_str("Marko123"));
`endif
        check_frame("t1", 40'h4D61726B6F, 12'h123);
        check("t1_ready_low", {63'd0, bus_if.ulaz_ready}, 64'd0);
        idle();
        check("t1_valid_drop", {63'd0, bus_if.izlaz_valid}, 64'd0);
        check("t1_ready_back", {63'd0, bus_if.ulaz_ready}, 64'd1);

        // Backpressure: koder not ready for 10 cycles, 'P' held on input
        bus_if.izlaz_ready = 1'b0;
        send_str("Marko123");
`ifdef KODER_CHECKSUM_EN
        send(xor_str("Marko123"));
`endif
        check_frame("t2", 40'h4D61726B6F, 12'h123);
        bus_if.ulaz_bajt  = "P";
        bus_if.ulaz_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_hold_ready", {63'd0, bus_if.ulaz_ready}, 64'd0);
            check_frame("t2_hold", 40'h4D61726B6F, 12'h123);
        end
        bus_if.izlaz_ready = 1'b1;
        tick();
        check("t2_xfer_valid", {63'd0, bus_if.izlaz_valid}, 64'd0);
        check("t2_xfer_ready", {63'd0, bus_if.ulaz_ready}, 64'd1);
        tick();
        send_str("etar456");
`ifdef KODER_CHECKSUM_EN
        send(xor_str("Petar456"));
`endif
        check_frame("t2_next", 40'h5065746172, 12'h456);
        idle();
        check("t2_next_drop", {63'd0, bus_if.izlaz_valid}, 64'd0);

        // Bad index digit
        send_str("Marko1A");
        check("t3_greska", {63'd0, bus_if.greska},      64'd1);
        check("t3_valid",  {63'd0, bus_if.izlaz_valid}, 64'd0);
        check("t3_ready",  {63'd0, bus_if.ulaz_ready},  64'd1);
        idle();
        check("t3_greska_pulse", {63'd0, bus_if.greska}, 64'd0);
        send_str("Petar456");
`ifdef KODER_CHECKSUM_EN
        send(xor_str("Petar456"));
`endif
        check_frame("t3", 40'h5065746172, 12'h456);
        idle();

        // Abort after 3 name bytes, byte offered in the abort cycle is dropped
        send_str("XYZ");
        bus_if.ponisti    = 1'b1;
        bus_if.ulaz_bajt  = "Q";
        bus_if.ulaz_valid = 1'b1;
        tick();
        bus_if.ponisti = 1'b0;
        check("t4_greska", {63'd0, bus_if.greska},     64'd0);
        check("t4_ready",  {63'd0, bus_if.ulaz_ready}, 64'd1);
        send_str("Ivana007");
`ifdef KODER_CHECKSUM_EN
        send(xor_str("Ivana007"));
`endif
        check_frame("t4", 40'h4976616E61, 12'h007);
        check("t4_no_greska", {63'd0, bus_if.greska}, 64'd0);
        idle();

        // Abort discards a held frame
        bus_if.izlaz_ready = 1'b0;
        send_str("Marko123");
`ifdef KODER_CHECKSUM_EN
        send(xor_str("Marko123"));
`endif
        check("t4b_held", {63'd0, bus_if.izlaz_valid}, 64'd1);
        bus_if.ulaz_valid = 1'b0;
        bus_if.ponisti    = 1'b1;
        tick();
        bus_if.ponisti = 1'b0;
        check("t4b_valid",  {63'd0, bus_if.izlaz_valid}, 64'd0);
        check("t4b_ready",  {63'd0, bus_if.ulaz_ready},  64'd1);
        check("t4b_greska", {63'd0, bus_if.greska},      64'd0);

        // Async reset in the middle of the index
        send_str("Marko1");
        bus_if.ulaz_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("t5_mid");
        tick();
        rst = 1'b0;

        // Async reset while a frame is held
        send_str("Marko123");
`ifdef KODER_CHECKSUM_EN
        send(xor_str("Marko123"));
`endif
        check("t5_held", {63'd0, bus_if.izlaz_valid}, 64'd1);
        bus_if.ulaz_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("t5_held_rst");
        #1 rst = 1'b0;
        bus_if.izlaz_ready = 1'b1;
        tick();
        send_str("Ivana007");
`ifdef KODER_CHECKSUM_EN
        send(xor_str("Ivana007"));
`endif
        check_frame("t5_after", 40'h4976616E61, 12'h007);
        idle();

`ifdef KODER_CHECKSUM_EN
        // Checksum: 'M'^'a'^'r'^'k'^'o'^'1'^'2'^'3' = 0x6A
        send_str("Marko123");
        send(8'h6A);
        check_frame("t6_ok", 40'h4D61726B6F, 12'h123);
        check("t6_ok_greska", {63'd0, bus_if.greska}, 64'd0);
        idle();
        send_str("Marko123");
        send(8'h6B);
        check("t6_bad_greska", {63'd0, bus_if.greska},      64'd1);
        check("t6_bad_valid",  {63'd0, bus_if.izlaz_valid}, 64'd0);
        idle();
        check("t6_bad_valid2", {63'd0, bus_if.izlaz_valid}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
